// File: rtl/ysyx_24110006_issue_ctrl.sv
// Issue scheduler between IDU and EXU: holds decoded instructions until register,
// CSR and serialization hazards clear, and tracks in-flight work until writeback.
module ysyx_24110006_issue_ctrl #(
    parameter int unsigned NR_REG       = 32,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [REG_W-1:0]  i_rs1,
    input  logic [REG_W-1:0]  i_rs2,
    input  logic              i_rs1_en,
    input  logic              i_rs2_en,
    input  logic [REG_W-1:0]  i_rd,
    input  logic              i_reg_wen,
    input  logic              i_csr,
    input  logic              i_serial,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_flush,
    input  logic              i_wb_valid,
    input  logic [REG_W-1:0]  i_wb_rd,
    input  logic              i_wb_reg_wen,
    input  logic              i_wb_csr,
    output logic [NR_REG-1:0] o_busy,
    output logic [CNT_W-1:0]  o_inflight,
    output logic [1:0]        o_state,
    output logic [31:0]       o_stall_cnt
);

    localparam int unsigned STALL_W = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SERIAL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NR_REG-1:0]    r_busy;
    logic [NR_REG-1:0]    w_busy_nxt;
    logic                 r_csr_busy;
    logic                 w_csr_busy_nxt;
    logic [CNT_W-1:0]     r_inflight;
    logic [CNT_W-1:0]     w_inflight_nxt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [STALL_W-1:0]   w_stall_cnt_nxt;

    logic w_raw;
    logic w_waw;
    logic w_csrh;
    logic w_full;
    logic w_ser;
    logic w_stall;
    logic w_fire;
    logic w_rd_set;
    logic w_wb_clr;

    // Hazards are evaluated only against registered state; no writeback bypass.
    assign w_raw  = (i_rs1_en & (i_rs1 != '0) & r_busy[i_rs1])
                  | (i_rs2_en & (i_rs2 != '0) & r_busy[i_rs2]);
    assign w_waw  = i_reg_wen & (i_rd != '0) & r_busy[i_rd];
    assign w_csrh = i_csr & r_csr_busy;
    assign w_full = (r_inflight == CNT_W'(MAX_INFLIGHT));
    assign w_ser  = (r_state == ST_SERIAL) | (i_serial & (r_inflight != '0));
    assign w_stall = w_raw | w_waw | w_csrh | w_full | w_ser;

    // A flush drops the wrong-path IDU instruction instead of issuing it.
    assign o_valid = i_valid & ~w_stall & ~i_flush;
    assign o_ready = (i_ready & ~w_stall) | i_flush;
    assign w_fire  = o_valid & i_ready;

    assign w_rd_set = w_fire & i_reg_wen & (i_rd != '0);
    assign w_wb_clr = i_wb_valid & i_wb_reg_wen & (i_wb_rd != '0);

    // Scoreboard, CSR reservation, occupancy and perf counter next values.
    always_comb begin
        w_busy_nxt      = r_busy;
        w_csr_busy_nxt  = r_csr_busy;
        w_inflight_nxt  = r_inflight;
        w_stall_cnt_nxt = r_stall_cnt;

        if (w_rd_set) begin
            w_busy_nxt[i_rd] = 1'b1;
        end
        if (w_wb_clr) begin
            w_busy_nxt[i_wb_rd] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;

        if (w_fire & i_csr) begin
            w_csr_busy_nxt = 1'b1;
        end
        if (i_wb_valid & i_wb_csr) begin
            w_csr_busy_nxt = 1'b0;
        end

        // Retire with nothing in flight is a protocol error; hold at zero.
        unique case ({w_fire, i_wb_valid})
            2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
            2'b01:   w_inflight_nxt = (r_inflight != '0) ? r_inflight - CNT_W'(1) : r_inflight;
            default: w_inflight_nxt = r_inflight;
        endcase

        if (i_valid & ~i_flush & w_stall) begin
            w_stall_cnt_nxt = r_stall_cnt + STALL_W'(1);
        end
    end

    // Serialization FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_fire & i_serial) begin
                    w_state_nxt = ST_SERIAL;
                end else if (i_valid & i_serial & (r_inflight != '0) & ~i_flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_fire & i_serial) begin
                    w_state_nxt = ST_SERIAL;
                end else if (i_flush | ~i_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SERIAL: begin
                if (i_wb_valid & (r_inflight == CNT_W'(1))) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_busy      <= '0;
            r_csr_busy  <= 1'b0;
            r_inflight  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_csr_busy  <= w_csr_busy_nxt;
            r_inflight  <= w_inflight_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_inflight  = r_inflight;
    assign o_state     = r_state;
    assign o_stall_cnt = r_stall_cnt;

endmodule
